bbox_accumulator: RTL and testbench

Downstream stage of the connected-components labeller. Consumes the per-pixel label stream (`cc_out`) with its x/y coordinates and accumulates a bounding box and pixel count for every non-zero label. At end of frame it dumps one record per populated label over a valid/ready handshake, then clears its table for the next frame. Its output is the object list that the overlay/host stage draws or reads back.

---
 rtl/bbox_accumulator.sv | 185 ++++++++++++++++++
 tb/tb_bbox_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bbox_accumulator.sv
// Per-label bounding box / pixel count accumulator fed by the CC labeller.
// Accumulates during the frame, dumps populated labels at frame end, then sweeps the table clear.
module bbox_accumulator #(
  parameter int LABEL_WIDTH = 8,
  parameter int COORD_WIDTH = 11,
  parameter int COUNT_WIDTH = 22
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [LABEL_WIDTH-1:0] label,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic                   frame_end,
  output logic                   busy,
  output logic                   lost,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LABEL_WIDTH-1:0] out_label,
  output logic [COORD_WIDTH-1:0] out_xmin,
  output logic [COORD_WIDTH-1:0] out_xmax,
  output logic [COORD_WIDTH-1:0] out_ymin,
  output logic [COORD_WIDTH-1:0] out_ymax,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   dump_done
);
  localparam int NUM = 1 << LABEL_WIDTH;
  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [LABEL_WIDTH-1:0] L_LAST = '1;
  localparam logic [COUNT_WIDTH-1:0] C_MAX  = '1;
  localparam logic [COORD_WIDTH-1:0] C_ONES = '1;

  logic [COORD_WIDTH-1:0] r_xmin [NUM];
  logic [COORD_WIDTH-1:0] r_xmax [NUM];
  logic [COORD_WIDTH-1:0] r_ymin [NUM];
  logic [COORD_WIDTH-1:0] r_ymax [NUM];
  logic [COUNT_WIDTH-1:0] r_cnt  [NUM];

  logic [1:0]             r_state;
  logic [LABEL_WIDTH-1:0] r_idx;
  logic                   r_drain, r_scan_done;

  logic                   r_s1_vld;
  logic [LABEL_WIDTH-1:0] r_s1_label;
  logic [COORD_WIDTH-1:0] r_s1_x, r_s1_y;
  logic [COORD_WIDTH-1:0] r_rd_xmin, r_rd_xmax, r_rd_ymin, r_rd_ymax;
  logic [COUNT_WIDTH-1:0] r_rd_cnt;

  logic [COORD_WIDTH-1:0] w_upd_xmin, w_upd_xmax, w_upd_ymin, w_upd_ymax;
  logic [COUNT_WIDTH-1:0] w_upd_cnt;
  logic                   w_take;

  logic                   r_out_valid, r_dump_done, r_lost;
  logic [LABEL_WIDTH-1:0] r_out_label;
  logic [COORD_WIDTH-1:0] r_out_xmin, r_out_xmax, r_out_ymin, r_out_ymax;
  logic [COUNT_WIDTH-1:0] r_out_count;

  assign busy      = (r_state != S_ACCUM) || r_drain;
  assign w_take    = en && (label != '0) && !busy;
  // reset kills a pending record immediately rather than one edge later
  assign out_valid = r_out_valid && !reset;
  assign dump_done = r_dump_done;
  assign lost      = r_lost;
  assign out_label = r_out_label;
  assign out_xmin  = r_out_xmin;
  assign out_xmax  = r_out_xmax;
  assign out_ymin  = r_out_ymin;
  assign out_ymax  = r_out_ymax;
  assign out_count = r_out_count;

  assign w_upd_xmin = (r_s1_x < r_rd_xmin) ? r_s1_x : r_rd_xmin;
  assign w_upd_xmax = (r_s1_x > r_rd_xmax) ? r_s1_x : r_rd_xmax;
  assign w_upd_ymin = (r_s1_y < r_rd_ymin) ? r_s1_y : r_rd_ymin;
  assign w_upd_ymax = (r_s1_y > r_rd_ymax) ? r_s1_y : r_rd_ymax;
  assign w_upd_cnt  = (r_rd_cnt == C_MAX) ? r_rd_cnt : r_rd_cnt + COUNT_WIDTH'(1);

  // Read stage: a same-label pixel in the update stage supersedes the stale table read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_take;
      if (w_take) begin
        r_s1_label <= label;
        r_s1_x     <= x;
        r_s1_y     <= y;
        if (r_s1_vld && (r_s1_label == label)) begin
          r_rd_xmin <= w_upd_xmin;
          r_rd_xmax <= w_upd_xmax;
          r_rd_ymin <= w_upd_ymin;
          r_rd_ymax <= w_upd_ymax;
          r_rd_cnt  <= w_upd_cnt;
        end else begin
          r_rd_xmin <= r_xmin[label];
          r_rd_xmax <= r_xmax[label];
          r_rd_ymin <= r_ymin[label];
          r_rd_ymax <= r_ymax[label];
          r_rd_cnt  <= r_cnt[label];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_xmin[r_idx] <= C_ONES;
      r_xmax[r_idx] <= '0;
      r_ymin[r_idx] <= C_ONES;
      r_ymax[r_idx] <= '0;
      r_cnt[r_idx]  <= '0;
    end else if (r_s1_vld) begin
      r_xmin[r_s1_label] <= w_upd_xmin;
      r_xmax[r_s1_label] <= w_upd_xmax;
      r_ymin[r_s1_label] <= w_upd_ymin;
      r_ymax[r_s1_label] <= w_upd_ymax;
      r_cnt[r_s1_label]  <= w_upd_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_drain     <= 1'b0;
      r_scan_done <= 1'b0;
      r_out_valid <= 1'b0;
      r_dump_done <= 1'b0;
      r_lost      <= 1'b0;
      r_out_label <= '0;
      r_out_xmin  <= '0;
      r_out_xmax  <= '0;
      r_out_ymin  <= '0;
      r_out_ymax  <= '0;
      r_out_count <= '0;
    end else begin
      r_dump_done <= 1'b0;
      if (busy && (en || frame_end)) r_lost <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + LABEL_WIDTH'(1);
          if (r_idx == L_LAST) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          // one drain cycle lets the frame_end pixel's write land before scanning
          if (r_drain) begin
            r_drain     <= 1'b0;
            r_state     <= S_DUMP;
            r_idx       <= LABEL_WIDTH'(1);
            r_scan_done <= 1'b0;
          end else if (frame_end) begin
            r_drain <= 1'b1;
          end
        end
        S_DUMP: begin
          if (!r_out_valid || out_ready) begin
            r_out_valid <= 1'b0;
            if (r_scan_done) begin
              r_dump_done <= 1'b1;
              r_state     <= S_CLEAR;
              r_idx       <= '0;
            end else begin
              if (r_cnt[r_idx] != '0) begin
                r_out_valid <= 1'b1;
                r_out_label <= r_idx;
                r_out_xmin  <= r_xmin[r_idx];
                r_out_xmax  <= r_xmax[r_idx];
                r_out_ymin  <= r_ymin[r_idx];
                r_out_ymax  <= r_ymax[r_idx];
                r_out_count <= r_cnt[r_idx];
              end
              r_idx <= r_idx + LABEL_WIDTH'(1);
              if (r_idx == L_LAST) r_scan_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_idx   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bbox_accumulator.sv
// Directed-vector bench for bbox_accumulator; expected records go to a queue
// and a negedge monitor checks each accepted record and stall stability.
module tb_bbox_accumulator;
  localparam int LW = 8, CW = 11, NW = 22;

  logic          clk = 1'b0, reset = 1'b1, en = 1'b0, frame_end = 1'b0, out_ready = 1'b1;
  logic [LW-1:0] label = '0;
  logic [CW-1:0] x = '0, y = '0;
  logic          busy, lost, out_valid, dump_done;
  logic [LW-1:0] out_label;
  logic [CW-1:0] out_xmin, out_xmax, out_ymin, out_ymax;
  logic [NW-1:0] out_count;

  typedef struct packed {
    logic [LW-1:0] l;
    logic [CW-1:0] x0, x1, y0, y1;
    logic [NW-1:0] c;
  } rec_t;

  rec_t exp_q[$];
  rec_t got, held, e;
  logic held_v = 1'b0;
  int   checks = 0, errors = 0, done_cnt = 0;

  bbox_accumulator #(.LABEL_WIDTH(LW), .COORD_WIDTH(CW), .COUNT_WIDTH(NW)) dut (
    .clk(clk), .reset(reset), .en(en), .label(label), .x(x), .y(y),
    .frame_end(frame_end), .busy(busy), .lost(lost), .out_valid(out_valid),
    .out_ready(out_ready), .out_label(out_label), .out_xmin(out_xmin),
    .out_xmax(out_xmax), .out_ymin(out_ymin), .out_ymax(out_ymax),
    .out_count(out_count), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic rec_t mk(int l, int x0, int x1, int y0, int y1, int c);
    rec_t r;
    r.l = LW'(l); r.x0 = CW'(x0); r.x1 = CW'(x1);
    r.y0 = CW'(y0); r.y1 = CW'(y1); r.c = NW'(c);
    return r;
  endfunction

  // monitor: compares accepted records in order and checks stalled records stay put
  always @(negedge clk) begin
    if (dump_done) done_cnt++;
    if (out_valid) begin
      got = {out_label, out_xmin, out_xmax, out_ymin, out_ymax, out_count};
      if (held_v) chk("hold_stable", got, held);
      if (out_ready) begin
        held_v = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record: got label %0d, none required", out_label);
        end else begin
          e = exp_q.pop_front();
          chk("record", got, e);
        end
      end else begin
        held = got;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int l, input int px, input int py);
    en = 1'b1; label = LW'(l); x = CW'(px); y = CW'(py);
    step();
    en = 1'b0; label = '0;
  endtask

  task automatic fend();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  // wait for dump_done (optionally toggling out_ready), then time the clear sweep
  task automatic wait_done(input bit tog);
    int n, d0;
    d0 = done_cnt;
    n = 0;
    while (!dump_done && n < 3000) begin
      step();
      if (tog) out_ready = ~out_ready;
      n++;
    end
    chk("dump_done_seen", dump_done, 1);
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("busy_fall_after_done", n, 256);
    chk("dump_done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_lost", lost, 0);
    chk("rst_dump_done", dump_done, 0);
    chk("rst_out_count", out_count, 0);
    reset = 1'b0;
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("busy_after_reset", n, 256);

    // empty frame
    fend();
    wait_done(1'b0);

    // forwarding: back-to-back same label
    exp_q.push_back(mk(5, 10, 12, 18, 25, 3));
    pix(5, 10, 20); pix(5, 12, 18); pix(5, 11, 25);
    fend();
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("first_valid_latency_ok", (n <= 7), 1);
    wait_done(1'b0);

    // interleaved labels with stalling consumer
    exp_q.push_back(mk(3, 4, 6, 2, 4, 2));
    exp_q.push_back(mk(7, 90, 100, 50, 60, 3));
    pix(3, 4, 4); pix(0, 1, 1); pix(7, 100, 50); pix(3, 6, 2); pix(0, 2, 2);
    pix(7, 90, 60); pix(7, 95, 55);
    fend();
    wait_done(1'b1);

    // pixels while busy are lost and excluded
    chk("lost_before", lost, 0);
    exp_q.push_back(mk(2, 1, 1, 1, 1, 1));
    pix(2, 1, 1);
    fend();
    pix(9, 30, 30); pix(9, 31, 31); pix(9, 32, 32);
    wait_done(1'b0);
    chk("lost_set", lost, 1);
    exp_q.push_back(mk(4, 2, 2, 2, 2, 1));
    pix(4, 2, 2);
    fend();
    wait_done(1'b0);
    chk("lost_sticky", lost, 1);

    // reset mid-dump with a record pending
    exp_q.push_back(mk(10, 3, 3, 3, 3, 1));
    exp_q.push_back(mk(20, 4, 4, 4, 4, 1));
    out_ready = 1'b0;
    pix(10, 3, 3); pix(20, 4, 4);
    fend();
    n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    chk("pending_valid", out_valid, 1);
    step();
    reset = 1'b1;
    #1;
    chk("valid_drop_in_reset", out_valid, 0);
    step();
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    chk("lost_cleared_by_reset", lost, 0);
    n = 0;
    while (busy && n < 1000) begin
      step();
      n++;
    end
    chk("busy_after_abort", n, 256);
    exp_q.push_back(mk(30, 7, 7, 8, 8, 1));
    pix(30, 7, 8);
    fend();
    wait_done(1'b0);

    // pixel on the frame_end cycle itself
    exp_q.push_back(mk(1, 0, 5, 0, 5, 2));
    pix(1, 5, 5);
    en = 1'b1; label = LW'(1); x = '0; y = '0; frame_end = 1'b1;
    step();
    en = 1'b0; label = '0; frame_end = 1'b0;
    wait_done(1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
